set_assoc_cache_ctrl: RTL and testbench

SET_ASSOC_CACHE_CTRL -- requirements
Module: set_assoc_cache_ctrl

---
 rtl/set_assoc_cache_ctrl.sv | 176 +++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_ctrl.sv
// Write-through, no-write-allocate set-associative cache controller.
// Tree pseudo-LRU replacement, 64-bit lines, single-word SRAM interface.
module set_assoc_cache_ctrl #(
  parameter int WAYS    = 2,
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  output logic [31:0] Rdata,
  output logic        ready,
  input  logic [63:0] Sram_rdata,
  input  logic        Sram_Ready,
  output logic [31:0] Sram_Address,
  output logic [31:0] Sram_Wdata,
  output logic        Sram_read,
  output logic        Sram_write,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W - 3;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = (WAYS > 2) ? 2 : 1;
  localparam int LRU_W = WAYS - 1;

  typedef enum logic [1:0] {IDLE, RMISS, WR} state_t;

  state_t                         state_q;
  logic [63:0]                    data_q [SETS][WAYS];
  logic [TAG_W-1:0]               tag_q  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]      valid_q;
  logic [SETS-1:0][LRU_W-1:0]     lru_q;
  logic [15:0]                    hit_count_q, miss_count_q;

  logic               word_sel;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [WAYS-1:0]    way_hit;
  logic               hit;
  logic [WAY_W-1:0]   hit_way, victim;
  logic [63:0]        hit_line;
  logic [2:0]         lru_cur;
  logic               rd_req, wr_req;
  logic               unused_addr;

  assign word_sel    = address[2];
  assign idx         = address[INDEX_W+2:3];
  assign tag         = address[ADDR_W-1:INDEX_W+3];
  assign unused_addr = ^{address[31:ADDR_W], address[1:0]};
  assign wr_req      = MEM_W_EN;
  assign rd_req      = MEM_R_EN & ~MEM_W_EN;
  assign lru_cur     = 3'(lru_q[idx]);

  // Tree bits point toward the LRU half: b0 selects left/right pair, b1/b2 the way within it.
  function automatic logic [1:0] plru_pick(input logic [2:0] b);
    if (WAYS == 2) return {1'b0, b[0]};
    return b[0] ? (b[2] ? 2'd3 : 2'd2) : (b[1] ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] n;
    n = b;
    if (WAYS == 2) begin
      n[0] = ~w[0];
    end else begin
      n[0] = ~w[1];
      if (w[1]) n[2] = ~w[0];
      else      n[1] = ~w[0];
    end
    return n;
  endfunction

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign way_hit[gi] = valid_q[idx][gi] && (tag_q[idx][gi] == tag);
  end

  assign hit      = |way_hit;
  assign hit_line = data_q[idx][hit_way];

  always_comb begin
    hit_way = '0;
    victim  = WAY_W'(plru_pick(lru_cur));
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w])        hit_way = WAY_W'(w);
      if (!valid_q[idx][w])  victim  = WAY_W'(w);
    end
  end

  always_comb begin
    ready        = 1'b0;
    Rdata        = '0;
    Sram_Address = '0;
    Sram_Wdata   = '0;
    Sram_read    = 1'b0;
    Sram_write   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          ready = hit;
          if (hit) Rdata = word_sel ? hit_line[63:32] : hit_line[31:0];
        end else if (!wr_req) begin
          ready = 1'b1;
        end
      end
      RMISS: begin
        Sram_read    = 1'b1;
        Sram_Address = address;
        if (Sram_Ready) begin
          ready = 1'b1;
          Rdata = word_sel ? Sram_rdata[63:32] : Sram_rdata[31:0];
        end
      end
      WR: begin
        Sram_write   = 1'b1;
        Sram_Address = address;
        Sram_Wdata   = wdata;
        ready        = Sram_Ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      lru_q        <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            state_q <= WR;
          end else if (rd_req) begin
            if (hit) begin
              lru_q[idx] <= LRU_W'(plru_touch(lru_cur, 2'(hit_way)));
              if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
            end else begin
              state_q <= RMISS;
            end
          end
        end
        RMISS: if (Sram_Ready) begin
          valid_q[idx][victim] <= 1'b1;
          lru_q[idx]           <= LRU_W'(plru_touch(lru_cur, 2'(victim)));
          if (miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
          state_q <= IDLE;
        end
        WR: if (Sram_Ready) begin
          if (hit) lru_q[idx] <= LRU_W'(plru_touch(lru_cur, 2'(hit_way)));
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; state_q is forced to IDLE while rst is high, so no write slips through.
  always_ff @(posedge clk) begin
    if (state_q == RMISS && Sram_Ready) begin
      data_q[idx][victim] <= Sram_rdata;
      tag_q[idx][victim]  <= tag;
    end else if (state_q == WR && Sram_Ready && hit) begin
      if (word_sel) data_q[idx][hit_way][63:32] <= wdata;
      else          data_q[idx][hit_way][31:0]  <= wdata;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed table-driven bench: a 2-way and a 4-way instance share stimulus, selected by sel.
module tb_set_assoc_cache_ctrl;
  logic        clk, rst, sel;
  logic [31:0] address, wdata;
  logic        r_en, w_en, sram_ready;
  logic [63:0] sram_rdata;

  logic [31:0] rdata2, saddr2, swdata2, rdata4, saddr4, swdata4;
  logic        ready2, sread2, swrite2, ready4, sread4, swrite4;
  logic [15:0] hc2, mc2, hc4, mc4;
  logic        r_en2, w_en2, srdy2, r_en4, w_en4, srdy4;

  logic [31:0] rdata, saddr, swdata;
  logic        ready, sread, swrite;
  logic [15:0] hc, mc;

  assign r_en2 = r_en & ~sel;  assign w_en2 = w_en & ~sel;  assign srdy2 = sram_ready & ~sel;
  assign r_en4 = r_en & sel;   assign w_en4 = w_en & sel;   assign srdy4 = sram_ready & sel;

  assign rdata  = sel ? rdata4  : rdata2;
  assign saddr  = sel ? saddr4  : saddr2;
  assign swdata = sel ? swdata4 : swdata2;
  assign ready  = sel ? ready4  : ready2;
  assign sread  = sel ? sread4  : sread2;
  assign swrite = sel ? swrite4 : swrite2;
  assign hc     = sel ? hc4     : hc2;
  assign mc     = sel ? mc4     : mc2;

  set_assoc_cache_ctrl #(.WAYS(2), .INDEX_W(6), .ADDR_W(18)) dut2 (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(r_en2), .MEM_W_EN(w_en2), .Rdata(rdata2), .ready(ready2),
    .Sram_rdata(sram_rdata), .Sram_Ready(srdy2), .Sram_Address(saddr2),
    .Sram_Wdata(swdata2), .Sram_read(sread2), .Sram_write(swrite2),
    .hit_count(hc2), .miss_count(mc2));

  set_assoc_cache_ctrl #(.WAYS(4), .INDEX_W(6), .ADDR_W(18)) dut4 (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .MEM_R_EN(r_en4), .MEM_W_EN(w_en4), .Rdata(rdata4), .ready(ready4),
    .Sram_rdata(sram_rdata), .Sram_Ready(srdy4), .Sram_Address(saddr4),
    .Sram_Wdata(swdata4), .Sram_read(sread4), .Sram_write(swrite4),
    .hit_count(hc4), .miss_count(mc4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        dut;
    logic        wr;
    logic        both;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        hit;
    logic [63:0] line;
    logic [31:0] exp;
    logic [15:0] hits;
    logic [15:0] misses;
  } vec_t;

  vec_t tbl [27];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic dut, input logic wr, input logic both,
                              input logic [31:0] addr, input logic [31:0] wd, input logic hit,
                              input logic [63:0] line, input logic [31:0] exp,
                              input logic [15:0] hits, input logic [15:0] misses);
    vec_t v;
    v.dut = dut; v.wr = wr; v.both = both; v.addr = addr; v.wd = wd; v.hit = hit;
    v.line = line; v.exp = exp; v.hits = hits; v.misses = misses;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_req(input int n, input vec_t v);
    @(negedge clk);
    sel = v.dut; address = v.addr; wdata = v.wd;
    w_en = v.wr; r_en = !v.wr || v.both;
    #1;
    $display("TXN %0d ways=%0d %s addr=%h wdata=%h", n, v.dut ? 4 : 2, v.wr ? "WR" : "RD", v.addr, v.wd);
    if (!v.wr && v.hit) begin
      chk("hit_ready", ready, 1'b1);
      chk("hit_rdata", rdata, v.exp);
      chk("hit_no_sram_read", sread, 1'b0);
      @(posedge clk); #1;
      r_en = 1'b0; w_en = 1'b0;
    end else begin
      chk("req_ready_low", ready, 1'b0);
      @(negedge clk);
      chk("c1_sram_read", sread, !v.wr);
      chk("c1_sram_write", swrite, v.wr);
      chk("c1_sram_addr", saddr, v.addr);
      chk("c1_sram_wdata", swdata, v.wr ? v.wd : 32'h0);
      chk("c1_ready_low", ready, 1'b0);
      @(negedge clk);
      chk("c2_ready_low", ready, 1'b0);
      @(negedge clk);
      sram_rdata = v.line; sram_ready = 1'b1;
      #1;
      chk("c3_ready", ready, 1'b1);
      if (!v.wr) chk("fill_rdata", rdata, v.exp);
      @(posedge clk); #1;
      sram_ready = 1'b0; r_en = 1'b0; w_en = 1'b0;
    end
    @(negedge clk);
    chk("hit_count", hc, v.hits);
    chk("miss_count", mc, v.misses);
    chk("idle_ready", ready, 1'b1);
  endtask

  initial begin
    // 2-way: fills, PLRU eviction, write-through and write-miss behaviour
    tbl[0]  = mk(0,0,0,32'h100,0,0,64'hBBBB_BBBB_AAAA_AAAA,32'hAAAA_AAAA,0,1);
    tbl[1]  = mk(0,0,0,32'h104,0,1,64'h0,32'hBBBB_BBBB,1,1);
    tbl[2]  = mk(0,0,0,32'h300,0,0,64'h1111_0304_1111_0300,32'h1111_0300,1,2);
    tbl[3]  = mk(0,0,0,32'h100,0,1,64'h0,32'hAAAA_AAAA,2,2);
    tbl[4]  = mk(0,0,0,32'h500,0,0,64'h5555_0504_5555_0500,32'h5555_0500,2,3);
    tbl[5]  = mk(0,0,0,32'h100,0,1,64'h0,32'hAAAA_AAAA,3,3);
    tbl[6]  = mk(0,0,0,32'h300,0,0,64'h1111_0304_1111_0300,32'h1111_0300,3,4);
    tbl[7]  = mk(0,1,0,32'h104,32'h1234_5678,0,64'h0,32'h0,3,4);
    tbl[8]  = mk(0,0,0,32'h104,0,1,64'h0,32'h1234_5678,4,4);
    tbl[9]  = mk(0,0,0,32'h100,0,1,64'h0,32'hAAAA_AAAA,5,4);
    tbl[10] = mk(0,1,0,32'h904,32'hDEAD_BEEF,0,64'h0,32'h0,5,4);
    tbl[11] = mk(0,0,0,32'h904,0,0,64'h9999_0904_9999_0900,32'h9999_0904,5,5);
    tbl[12] = mk(0,1,1,32'h104,32'hCAFE_F00D,0,64'h0,32'h0,5,5);
    tbl[13] = mk(0,0,0,32'h104,0,1,64'h0,32'hCAFE_F00D,6,5);
    // after a reset abandoned mid-fill
    tbl[14] = mk(0,0,0,32'h100,0,0,64'hBBBB_BBBB_AAAA_AAAA,32'hAAAA_AAAA,0,1);
    tbl[15] = mk(0,0,0,32'h104,0,1,64'h0,32'hBBBB_BBBB,1,1);
    // 4-way: fill all ways, touch way0, fifth tag must evict way2 (0x500)
    tbl[16] = mk(1,0,0,32'h100,0,0,64'h4444_0104_4444_0100,32'h4444_0100,0,1);
    tbl[17] = mk(1,0,0,32'h300,0,0,64'h4444_0304_4444_0300,32'h4444_0300,0,2);
    tbl[18] = mk(1,0,0,32'h500,0,0,64'h4444_0504_4444_0500,32'h4444_0500,0,3);
    tbl[19] = mk(1,0,0,32'h700,0,0,64'h4444_0704_4444_0700,32'h4444_0700,0,4);
    tbl[20] = mk(1,0,0,32'h100,0,1,64'h0,32'h4444_0100,1,4);
    tbl[21] = mk(1,0,0,32'h900,0,0,64'h4444_0904_4444_0900,32'h4444_0900,1,5);
    tbl[22] = mk(1,0,0,32'h104,0,1,64'h0,32'h4444_0104,2,5);
    tbl[23] = mk(1,0,0,32'h304,0,1,64'h0,32'h4444_0304,3,5);
    tbl[24] = mk(1,0,0,32'h700,0,1,64'h0,32'h4444_0700,4,5);
    tbl[25] = mk(1,0,0,32'h900,0,1,64'h0,32'h4444_0900,5,5);
    tbl[26] = mk(1,0,0,32'h500,0,0,64'h4444_0504_4444_0500,32'h4444_0500,5,6);

    rst = 1'b1; sel = 1'b0; address = '0; wdata = '0; r_en = 1'b0; w_en = 1'b0;
    sram_ready = 1'b0; sram_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_sram_read", sread, 1'b0);
    chk("rst_sram_write", swrite, 1'b0);
    chk("rst_hit_count", hc, 16'd0);
    chk("rst_miss_count", mc, 16'd0);

    for (int i = 0; i <= 13; i++) do_req(i, tbl[i]);

    // Reset pulsed mid-RMISS while clk is low: outputs must drop without any edge
    @(negedge clk);
    sel = 1'b0; address = 32'hA00; r_en = 1'b1;
    @(negedge clk);
    $display("TXN rst-mid-rmiss addr=%h", address);
    chk("pre_rst_sram_read", sread, 1'b1);
    #2 rst = 1'b1; r_en = 1'b0;
    #1;
    chk("async_rst_sram_read", sread, 1'b0);
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_hit_count", hc, 16'd0);
    chk("async_rst_miss_count", mc, 16'd0);
    #1 rst = 1'b0;

    for (int i = 14; i <= 26; i++) do_req(i, tbl[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
